// File: rtl/spi_host_fifo.sv
// spi_host_fifo: TX/RX byte FIFOs that drive the SPI core register port through a 5-state strobe FSM.
// Define SPI_HOST_TIMEOUT_EN to add a WAIT_RX timeout counter and the sticky timeout output.
module spi_host_fifo #(
   parameter int DEPTH          = 8,
   parameter int TX_READY_BIT   = 0,
   parameter int RX_VALID_BIT   = 1,
   parameter int WR_PULSE       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [7:0]             cfg_control,
   input  logic [7:0]             tx_data,
   input  logic                   tx_push,
   output logic                   tx_full,
   output logic [7:0]             rx_data,
   input  logic                   rx_pop,
   output logic                   rx_empty,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic [$clog2(DEPTH):0] rx_level,
   input  logic                   ovr_clr,
   output logic                   overrun,
`ifdef SPI_HOST_TIMEOUT_EN
   output logic                   timeout,
`endif
   output logic                   busy,
   output logic [7:0]             core_control,
   output logic [7:0]             core_data_out,
   output logic                   core_write,
   output logic                   core_read,
   input  logic [7:0]             core_data_in,
   input  logic [7:0]             core_status
);
   localparam int AW = $clog2(DEPTH);
   localparam int L  = AW + 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + WR_PULSE + 1);
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_RX, READ, STORE} state_t;
   state_t state, state_nxt;
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd, rx_rd_nxt;
   logic [L-1:0] rx_cnt_nxt;
   logic [CW-1:0] cnt;
   logic tx_push_ok, tx_pop, rx_pop_ok, rx_full, rx_push, drop, unused;
`ifdef SPI_HOST_TIMEOUT_EN
   logic time_out;
`endif
   assign tx_full    = tx_level == L'(DEPTH);
   assign rx_full    = rx_level == L'(DEPTH);
   assign rx_empty   = rx_level == '0;
   assign tx_push_ok = tx_push && !tx_full;
   assign tx_pop     = state == IDLE && tx_level != '0 && core_status[TX_READY_BIT];
   assign rx_pop_ok  = rx_pop && !rx_empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still take the byte
   assign rx_push    = state == STORE && (!rx_full || rx_pop_ok);
   assign drop       = state == STORE && !rx_push;
   assign rx_rd_nxt  = rx_rd + AW'(rx_pop_ok);
   assign rx_cnt_nxt = rx_level + L'(rx_push) - L'(rx_pop_ok);
   assign busy       = state != IDLE;
   assign core_write = state == LOAD;
   assign core_read  = state == READ;
   assign unused     = ^core_status;
   always_comb begin
      state_nxt = state;
`ifdef SPI_HOST_TIMEOUT_EN
      time_out  = 1'b0;
`endif
      case (state)
         IDLE:    state_nxt = tx_pop ? LOAD : IDLE;
         LOAD:    state_nxt = cnt == CW'(WR_PULSE - 1) ? WAIT_RX : LOAD;
         WAIT_RX: begin
            state_nxt = core_status[RX_VALID_BIT] ? READ : WAIT_RX;
`ifdef SPI_HOST_TIMEOUT_EN
            time_out  = !core_status[RX_VALID_BIT] && cnt == CW'(TIMEOUT_CYCLES - 1);
            state_nxt = time_out ? IDLE : state_nxt;
`endif
         end
         READ:    state_nxt = STORE;
         STORE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wr] <= tx_data;
      if (rx_push) rx_mem[rx_wr] <= core_data_in;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state         <= IDLE;
         cnt           <= '0;
         tx_wr         <= '0;
         tx_rd         <= '0;
         rx_wr         <= '0;
         rx_rd         <= '0;
         tx_level      <= '0;
         rx_level      <= '0;
         rx_data       <= 8'h00;
         overrun       <= 1'b0;
         core_control  <= 8'h00;
         core_data_out <= 8'h00;
`ifdef SPI_HOST_TIMEOUT_EN
         timeout       <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         cnt           <= state_nxt != state ? '0 : cnt + CW'(1);
         core_control  <= cfg_control;
         core_data_out <= tx_pop ? tx_mem[tx_rd] : core_data_out;
         tx_wr         <= tx_wr + AW'(tx_push_ok);
         tx_rd         <= tx_rd + AW'(tx_pop);
         tx_level      <= tx_level + L'(tx_push_ok) - L'(tx_pop);
         rx_wr         <= rx_wr + AW'(rx_push);
         rx_rd         <= rx_rd_nxt;
         rx_level      <= rx_cnt_nxt;
         // head register tracks the post-update head, bypassing a byte written straight into the head slot
         rx_data       <= rx_cnt_nxt == '0 ? 8'h00 :
                          (rx_push && rx_wr == rx_rd_nxt) ? core_data_in : rx_mem[rx_rd_nxt];
         overrun       <= drop || (overrun && !ovr_clr);
`ifdef SPI_HOST_TIMEOUT_EN
         timeout       <= time_out || (timeout && !ovr_clr);
`endif
      end
   end
endmodule

// File: tb/tb_spi_host_fifo.sv
// tb_spi_host_fifo: scoreboard bench for spi_host_fifo with a behavioural SPI core responder.
// The responder answers every byte b with b ^ 8'h1D; build with SPI_HOST_TIMEOUT_EN to exercise the timeout.
module tb_spi_host_fifo;
   localparam int WRP = 2;
   logic clk = 1'b0, clr, tx_push, rx_pop, ovr_clr, tx_full, rx_empty, overrun, busy, core_write, core_read;
   logic [7:0] cfg_control, tx_data, rx_data, core_control, core_data_out, core_data_in, core_status;
   logic [3:0] tx_level, rx_level;
`ifdef SPI_HOST_TIMEOUT_EN
   logic timeout;
`endif
   logic rx_valid = 1'b0;
   bit tx_ready_en = 1'b1, hold_rx = 1'b0, check_gap = 1'b0;
   int rx_delay = 10, writes = 0, reads = 0, last_rise = -1, cyc = 0;
   int vectors = 0, miscompares = 0;
   logic [7:0] tx_exp[$], rx_exp[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign core_status = {6'b0, rx_valid, tx_ready_en};

   spi_host_fifo #(.DEPTH(8), .WR_PULSE(WRP), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .clr(clr), .cfg_control(cfg_control), .tx_data(tx_data), .tx_push(tx_push),
      .tx_full(tx_full), .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty),
      .tx_level(tx_level), .rx_level(rx_level), .ovr_clr(ovr_clr), .overrun(overrun),
`ifdef SPI_HOST_TIMEOUT_EN
      .timeout(timeout),
`endif
      .busy(busy), .core_control(core_control), .core_data_out(core_data_out),
      .core_write(core_write), .core_read(core_read), .core_data_in(core_data_in),
      .core_status(core_status));

   // core responder: checks each byte against the TX scoreboard and answers after rx_delay cycles
   initial begin
      logic prev_w, prev_r;
      logic [7:0] wdata, e;
      int wlen, countdown;
      prev_w = 1'b0; prev_r = 1'b0; wlen = 0; countdown = -1; wdata = 8'h00; core_data_in = 8'h00;
      forever begin
         @(negedge clk);
         if (clr) begin
            rx_valid = 1'b0; countdown = -1; prev_w = 1'b0; prev_r = 1'b0; wlen = 0;
         end else begin
            if (core_write) begin
               if (!prev_w) begin
                  writes++; vectors++;
                  if (tx_exp.size() == 0) begin
                     miscompares++; $display("FAIL core_byte: got %h, none expected", core_data_out);
                  end else begin
                     e = tx_exp.pop_front();
                     if (core_data_out !== e) begin
                        miscompares++; $display("FAIL core_byte: got %h required %h", core_data_out, e);
                     end
                  end
                  if (check_gap && last_rise >= 0) begin
                     vectors++;
                     if (cyc - last_rise !== 6) begin
                        miscompares++; $display("FAIL turnaround: got %0d required 6", cyc - last_rise);
                     end
                  end
                  last_rise = cyc; wdata = core_data_out; wlen = 0;
               end
               wlen++; vectors++;
               if (core_data_out !== wdata) begin
                  miscompares++; $display("FAIL data_stable: got %h required %h", core_data_out, wdata);
               end
            end else if (prev_w) begin
               vectors++;
               if (wlen !== WRP) begin
                  miscompares++; $display("FAIL write_pulse: got %0d required %0d", wlen, WRP);
               end
               if (!hold_rx) countdown = rx_delay;
            end
            if (countdown == 0) begin
               rx_valid = 1'b1; core_data_in = wdata ^ 8'h1D; countdown = -1;
            end else if (countdown > 0) countdown--;
            if (core_read) begin
               reads++; vectors++; rx_valid = 1'b0;
               if (prev_r) begin
                  miscompares++; $display("FAIL read_pulse: got 2+ cycles required 1");
               end
            end
            prev_w = core_write; prev_r = core_read;
         end
      end
   end

   task automatic push(input logic [7:0] b, input bit accept, input bit store);
      tx_data = b; tx_push = 1'b1;
      if (accept) tx_exp.push_back(b);
      if (accept && store) rx_exp.push_back(b ^ 8'h1D);
      @(negedge clk);
      tx_push = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((tx_level != 0 || busy) && n < budget) begin
         @(negedge clk); n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++; $display("FAIL wait_done: still busy after %0d cycles", budget);
      end
   endtask

   task automatic drain();
      logic [7:0] e;
      int g = 0;
      while (!rx_empty && g < 20) begin
         vectors++;
         if (rx_exp.size() == 0) begin
            miscompares++; $display("FAIL rx_data: got %h, none expected", rx_data);
         end else begin
            e = rx_exp.pop_front();
            if (rx_data !== e) begin
               miscompares++; $display("FAIL rx_data: got %h required %h", rx_data, e);
            end
         end
         rx_pop = 1'b1; @(negedge clk); rx_pop = 1'b0; g++;
      end
      vectors++;
      if (rx_exp.size() != 0) begin
         miscompares++; $display("FAIL rx_drain: %0d bytes missing", rx_exp.size());
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({tx_level, rx_level, tx_full, rx_empty, overrun, busy, core_write, core_read} !== 14'b0000_0000_0_1_0_0_0_0) begin
         miscompares++;
         $display("FAIL reset_flags: got lvl %0d/%0d full %b empty %b ovr %b busy %b wr %b rd %b required 0/0 0 1 0 0 0 0",
                  tx_level, rx_level, tx_full, rx_empty, overrun, busy, core_write, core_read);
      end
      vectors++;
      if ({core_data_out, core_control, rx_data} !== 24'h0) begin
         miscompares++; $display("FAIL reset_data: got %h %h %h required 00 00 00", core_data_out, core_control, rx_data);
      end
   endtask

   task automatic test_control();
      clr = 1'b0; @(negedge clk);
      vectors++;
      if (core_control !== 8'h5A) begin
         miscompares++; $display("FAIL control_release: got %h required 5a", core_control);
      end
      cfg_control = 8'hA7; #1;
      vectors++;
      if (core_control !== 8'h5A) begin
         miscompares++; $display("FAIL control_latency: got %h required 5a", core_control);
      end
      @(negedge clk);
      vectors++;
      if (core_control !== 8'hA7) begin
         miscompares++; $display("FAIL control_update: got %h required a7", core_control);
      end
   endtask

   task automatic test_single();
      int w0 = writes, r0 = reads;
      rx_delay = 10;
      push(8'h50, 1'b1, 1'b1);
      wait_done(100);
      vectors++;
      if (writes !== w0 + 1 || reads !== r0 + 1 || rx_level !== 4'd1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL single: got wr %0d rd %0d lvl %0d busy %b required 1 1 1 0",
                                 writes - w0, reads - r0, rx_level, busy);
      end
      vectors++;
      if (rx_data !== 8'h4D) begin
         miscompares++; $display("FAIL single_rx: got %h required 4d", rx_data);
      end
      drain();
   endtask

   task automatic test_burst();
      logic [7:0] burst [9] = '{8'h54, 8'h6C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hEE};
      tx_ready_en = 1'b0; rx_delay = 3;
      for (int i = 0; i < 9; i++) begin
         push(burst[i], i < 8, 1'b1);
         if (i == 7) begin
            vectors++;
            if (tx_full !== 1'b1 || tx_level !== 4'd8) begin
               miscompares++; $display("FAIL burst_full: got full %b lvl %0d required 1 8", tx_full, tx_level);
            end
         end
      end
      vectors++;
      if (tx_level !== 4'd8) begin
         miscompares++; $display("FAIL burst_ninth: got lvl %0d required 8", tx_level);
      end
      tx_ready_en = 1'b1;
      wait_done(300);
      vectors++;
      if (rx_level !== 4'd8 || overrun !== 1'b0) begin
         miscompares++; $display("FAIL burst_rx: got lvl %0d ovr %b required 8 0", rx_level, overrun);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int w0 = writes;
      rx_delay = 0; last_rise = -1; check_gap = 1'b1;
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b1, 1'b1);
      wait_done(100);
      check_gap = 1'b0;
      vectors++;
      if (writes !== w0 + 4) begin
         miscompares++; $display("FAIL b2b_count: got %0d required 4", writes - w0);
      end
      drain();
   endtask

   task automatic test_overrun();
      int n = 0;
      logic [7:0] e;
      rx_delay = 0;
      for (int i = 0; i < 9; i++) push(8'h80 + 8'(i), 1'b1, i < 8);
      wait_done(200);
      vectors++;
      if (rx_level !== 4'd8 || overrun !== 1'b1) begin
         miscompares++; $display("FAIL overrun_set: got lvl %0d ovr %b required 8 1", rx_level, overrun);
      end
      ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++; $display("FAIL overrun_clr: got %b required 0", overrun);
      end
      push(8'h77, 1'b1, 1'b1);
      while (!core_read && n < 50) begin
         @(negedge clk); n++;
      end
      vectors++;
      if (n >= 50) begin
         miscompares++; $display("FAIL popwin_wait: no core_read within 50 cycles");
      end
      @(negedge clk);
      vectors++;
      e = rx_exp.pop_front();
      if (rx_data !== e) begin
         miscompares++; $display("FAIL popwin_head: got %h required %h", rx_data, e);
      end
      rx_pop = 1'b1; @(negedge clk); rx_pop = 1'b0;
      vectors++;
      if (overrun !== 1'b0 || rx_level !== 4'd8) begin
         miscompares++; $display("FAIL popwin: got ovr %b lvl %0d required 0 8", overrun, rx_level);
      end
      drain();
   endtask

   task automatic test_flow_control();
      int w0 = writes;
      tx_ready_en = 1'b0; rx_delay = 2;
      for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      vectors++;
      if (writes !== w0 || tx_level !== 4'd3 || busy !== 1'b0) begin
         miscompares++; $display("FAIL flow_hold: got wr %0d lvl %0d busy %b required 0 3 0", writes - w0, tx_level, busy);
      end
      tx_ready_en = 1'b1;
      wait_done(100);
      vectors++;
      if (writes !== w0 + 3) begin
         miscompares++; $display("FAIL flow_resume: got %0d writes required 3", writes - w0);
      end
      drain();
   endtask

   task automatic test_reset_mid_load();
      int n = 0;
      rx_delay = 2;
      push(8'h33, 1'b1, 1'b1);
      while (!core_write && n < 20) begin
         @(negedge clk); n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++; $display("FAIL midload_wait: no core_write within 20 cycles");
      end
      clr = 1'b1; @(negedge clk);
      vectors++;
      if (core_write !== 1'b0 || tx_level !== 4'd0 || rx_level !== 4'd0 || busy !== 1'b0 || rx_empty !== 1'b1) begin
         miscompares++; $display("FAIL midload_reset: got wr %b lvl %0d/%0d busy %b empty %b required 0 0/0 0 1",
                                 core_write, tx_level, rx_level, busy, rx_empty);
      end
      rx_exp.delete(); tx_exp.delete();
      @(negedge clk); clr = 1'b0; @(negedge clk);
   endtask

`ifdef SPI_HOST_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      hold_rx = 1'b1;
      push(8'h42, 1'b1, 1'b0);
      while (!core_write && n < 20) begin
         @(negedge clk); n++;
      end
      while (core_write && n < 40) begin
         @(negedge clk); n++;
      end
      vectors++;
      if (n >= 40) begin
         miscompares++; $display("FAIL timeout_wait: WAIT_RX not reached");
      end
      repeat (15) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
         miscompares++; $display("FAIL timeout_early: got busy %b to %b required 1 0", busy, timeout);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || timeout !== 1'b1 || rx_level !== 4'd0) begin
         miscompares++; $display("FAIL timeout_fire: got busy %b to %b lvl %0d required 0 1 0", busy, timeout, rx_level);
      end
      ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
      vectors++;
      if (timeout !== 1'b0) begin
         miscompares++; $display("FAIL timeout_clr: got %b required 0", timeout);
      end
      hold_rx = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1; tx_push = 1'b0; rx_pop = 1'b0; ovr_clr = 1'b0; tx_data = 8'h00; cfg_control = 8'h5A;
      repeat (3) @(negedge clk);
      test_reset();
      test_control();
      test_single();
      test_burst();
      test_back_to_back();
      test_overrun();
      test_flow_control();
      test_reset_mid_load();
`ifdef SPI_HOST_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
